uart_transmitter: RTL and testbench
===================================

# uart_transmitter

Transmit half of the UART link. Serialises one byte per request into an 11-bit frame: start bit, 8 data bits LSB first, even parity, stop bit. Each bit is held for 16 oversample ticks from an internal baud divider with the same eight selectable rates as the receive side. It pairs back-to-back with the receiver over a single wire (`txd` to `RxD`).

## Interface
- `CLK_FREQ`, default 100_000_000: clk frequency in Hz.
- Divisor rule: DIV = (CLK_FREQ + 8·baud) / (16·baud), integer division, per rate.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `baud_select`  in  3  rate: 000=300, 001=1200, 010=4800, 011=9600, 100=19200, 101=38400, 110=57600, 111=115200.
- `tx_en`  in  1  transmitter enable; gates acceptance of new requests.
- `tx_wr`  in  1  write strobe; request to send `tx_data`.
- `tx_data`  in  8  byte to send.
- `txd`  out  1  serial line; idle high.
- `tx_busy`  out  1  frame in progress.
- `tx_done`  out  1  one-cycle pulse at end of stop bit.

## Operation
- Divisors at 100 MHz: 20833, 5208, 1302, 651, 326, 163, 109, 54.
- Divider: counter runs 0..DIV-1 and emits tick at DIV-1. Sample counter runs 0..15; the bit boundary is tick with sample counter at 15. Bit period is exactly 16·DIV clk cycles.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: `txd`=1. Accept when `tx_wr`=1, `tx_en`=1 and state is IDLE.
- On accept, all in the same edge:
  - latch `tx_data` into the shift register;
  - latch `baud_select` into the active divisor;
  - compute parity = XOR of the 8 data bits (even parity);
  - clear the divider, sample counter and bit index;
  - go to START.
- START: `txd`=0 for one bit period, then DATA.
- DATA: `txd` = data[bit index], index 0..7. After the bit with index 7, go to PARITY.
- PARITY: `txd` = parity bit for one bit period, then STOP.
- STOP: `txd`=1 for one bit period, then IDLE with `tx_done`=1 for one cycle.
- `tx_busy`=1 in every state except IDLE.
- `tx_wr` while busy: ignored, not queued.
- `tx_wr` while `tx_en`=0: ignored.
- `tx_en` dropped mid-frame: the current frame completes normally.
- `baud_select` changed mid-frame: no effect until the next accepted frame.
- `tx_data` changed after accept: no effect on the frame in progress.
- `rst`, including mid-frame: the next edge forces IDLE with `txd`=1, `tx_busy`=0, `tx_done`=0, and clears all counters. No partial frame resumes.

## Timing
- Reset values: `txd`=1, `tx_busy`=0, `tx_done`=0.
- Accept edge T: from T+1, `txd`=0 and `tx_busy`=1.
- Bit k (k=0 start … 10 stop) occupies cycles T+1+16·DIV·k through T+16·DIV·(k+1).
- `tx_done`=1 and `tx_busy`=0 in cycle T+1+176·DIV.
- The whole frame is 176·DIV cycles of busy.
- Back-to-back: a `tx_wr` sampled in the `tx_done` cycle is accepted. The next start bit begins one cycle later, so the minimum idle-high gap after the stop bit is one clk.
- All outputs are registered. No combinational path from inputs to `txd`, `tx_busy` or `tx_done`.

## Test plan
- **0xAA at 111 (DIV=54).** Required `txd`, each bit held 864 cycles: 0,0,1,0,1,0,1,0,1,0,1 (parity 0). `tx_busy` is high for 9504 cycles, then `tx_done` pulses once.
- **0x89 at 111.** Data bits LSB first are 1,0,0,1,0,0,0,1; parity is 1. Bytes 0x55 and 0xCC give parity 0. The receiver loopback shows `Rx_DATA` equal to each byte with `Rx_VALID`=1 and no error flags.
- **All eight rates in turn, 0x55 each.** The measured bit period equals 16·DIV for each rate: 333328 cycles for 000 down to 864 for 111.
- **`tx_wr` pulsed with 0x33 mid-frame of 0xAA.** 0x33 is never sent and the 0xAA frame is unchanged. Changing `baud_select` and `tx_data` mid-frame also leaves the frame unchanged.
- **`tx_en`=0 with `tx_wr`=1.** `tx_busy` stays 0 and `txd` stays 1. Drop `tx_en` during bit 4 of a frame: the frame still completes with `tx_done`.
- **`rst` asserted during DATA, and back-to-back writes.**
  - On the next edge after `rst`: `txd`=1, `tx_busy`=0.
  - After release, a new 0xCC frame is sent correctly from its start bit.
  - `tx_wr` held high: consecutive frames are separated by exactly one idle cycle.

Source files
------------

// File: rtl/uart_transmitter.sv
// uart_transmitter: 8E1 UART transmitter with 16x oversampled baud divider
//   clk, rst      : clock, synchronous active-high reset
//   baud_select   : rate code, latched per frame (300 .. 115200 baud)
//   tx_en, tx_wr  : enable and write strobe; a write is accepted only when idle
//   tx_data       : byte to send, latched on accept
//   txd           : serial line, idle high
//   tx_busy       : frame in progress
//   tx_done       : one-cycle pulse at end of stop bit
module uart_transmitter #(
    parameter int CLK_FREQ = 100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] baud_select,
    input  logic       tx_en,
    input  logic       tx_wr,
    input  logic [7:0] tx_data,
    output logic       txd,
    output logic       tx_busy,
    output logic       tx_done
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    localparam int BAUD [8] = '{300, 1200, 4800, 9600, 19200, 38400, 57600, 115200};
    state_t      state;
    logic [31:0] div;
    logic [31:0] cnt;
    logic [3:0]  smp;
    logic [2:0]  idx;
    logic [7:0]  shreg;
    logic        par;
    logic        tick;
    logic        bit_end;
    // rounded divisor: (CLK_FREQ + 8*baud) / (16*baud)
    function automatic logic [31:0] div_of(input logic [2:0] s);
        return 32'((CLK_FREQ + 8 * BAUD[s]) / (16 * BAUD[s]));
    endfunction
    assign tick    = cnt == div - 32'd1;
    assign bit_end = tick && smp == 4'd15;
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            div     <= 32'd1;
            cnt     <= '0;
            smp     <= '0;
            idx     <= '0;
            shreg   <= '0;
            par     <= 1'b0;
            txd     <= 1'b1;
            tx_busy <= 1'b0;
            tx_done <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (state == IDLE) begin
                if (tx_wr && tx_en) begin
                    state   <= START;
                    shreg   <= tx_data;
                    div     <= div_of(baud_select);
                    par     <= ^tx_data;
                    cnt     <= '0;
                    smp     <= '0;
                    idx     <= '0;
                    txd     <= 1'b0;
                    tx_busy <= 1'b1;
                end
            end else begin
                cnt <= tick ? '0 : cnt + 32'd1;
                smp <= tick ? smp + 4'd1 : smp;
                if (bit_end) begin
                    unique case (state)
                        START: begin
                            state <= DATA;
                            txd   <= shreg[0];
                        end
                        DATA: begin
                            // shreg[1] is the next data bit once the current LSB shifts out
                            state <= idx == 3'd7 ? PARITY : DATA;
                            txd   <= idx == 3'd7 ? par : shreg[1];
                            shreg <= shreg >> 1;
                            idx   <= idx + 3'd1;
                        end
                        PARITY: begin
                            state <= STOP;
                            txd   <= 1'b1;
                        end
                        default: begin
                            state   <= IDLE;
                            txd     <= 1'b1;
                            tx_busy <= 1'b0;
                            tx_done <= 1'b1;
                        end
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: directed checks of frame format, timing, rates and control corner cases
module tb_uart_transmitter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] baud_select = 3'b111;
    logic       tx_en = 1'b1;
    logic       tx_wr = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       txd0, busy0, done0;
    logic       txd1, busy1, done1;
    int         total = 0;
    int         passed = 0;

    // dut0: 100 MHz (DIV 54 at 115200); dut1: 1.8432 MHz (DIV 384 .. 1) for short frames
    uart_transmitter dut0 (
        .clk(clk), .rst(rst), .baud_select(baud_select), .tx_en(tx_en), .tx_wr(tx_wr),
        .tx_data(tx_data), .txd(txd0), .tx_busy(busy0), .tx_done(done0)
    );
    uart_transmitter #(.CLK_FREQ(1_843_200)) dut1 (
        .clk(clk), .rst(rst), .baud_select(baud_select), .tx_en(tx_en), .tx_wr(tx_wr),
        .tx_data(tx_data), .txd(txd1), .tx_busy(busy1), .tx_done(done1)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] outs(input bit w);
        return w ? {txd1, busy1, done1} : {txd0, busy0, done0};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1);
        rst = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input logic [2:0] s);
        tx_data = d;
        baud_select = s;
        tx_wr = 1'b1;
        step(1);
        tx_wr = 1'b0;
    endtask

    // called in the first cycle after the accept edge; returns in the tx_done cycle
    task automatic frame_check(input bit w, input logic [10:0] f, input int p, input string nm);
        logic [2:0] o;
        for (int k = 0; k < 11; k++) begin
            logic       ok;
            logic [2:0] bad;
            ok = 1'b1;
            bad = 3'b000;
            for (int c = 0; c < p; c++) begin
                o = outs(w);
                if (ok && o !== {f[k], 2'b10}) begin
                    ok = 1'b0;
                    bad = o;
                end
                step(1);
            end
            total++;
            if (!ok) $display("FAIL %s bit%0d: txd,busy,done=%b required %b for %0d cycles", nm, k, bad, {f[k], 2'b10}, p);
            else passed++;
        end
        o = outs(w);
        total++;
        if (o !== 3'b101) $display("FAIL %s end: txd,busy,done=%b required 101", nm, o);
        else passed++;
    endtask

    task automatic measure(input bit w, input logic [2:0] s, input int p);
        logic [2:0] o;
        int n;
        do_reset();
        send(8'h55, s);
        n = 0;
        o = outs(w);
        while (o[2] === 1'b0 && n <= p) begin
            n++;
            step(1);
            o = outs(w);
        end
        total++;
        if (n !== p) $display("FAIL rate dut%0d sel=%b: start bit %0d cycles required %0d", w, s, n, p);
        else passed++;
        do_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(3);
        rst = 1'b0;
        total++;
        if ({outs(0), outs(1)} !== 6'b100100) $display("FAIL reset: outs=%b required 100100", {outs(0), outs(1)});
        else passed++;
    endtask

    task automatic test_aa();
        do_reset();
        send(8'hAA, 3'b111);
        frame_check(0, 11'h554, 864, "aa_100mhz");
        step(1);
        total++;
        if (outs(0) !== 3'b100) $display("FAIL aa_done_pulse: txd,busy,done=%b required 100", outs(0));
        else passed++;
    endtask

    task automatic test_bytes();
        logic [7:0]  d [3] = '{8'h89, 8'h55, 8'hCC};
        logic [10:0] f [3] = '{11'h712, 11'h4AA, 11'h598};
        for (int i = 0; i < 3; i++) begin
            do_reset();
            send(d[i], 3'b111);
            frame_check(1, f[i], 16, $sformatf("byte_%h", d[i]));
        end
        do_reset();
        send(8'h89, 3'b111);
        frame_check(0, 11'h712, 864, "byte_89_100mhz");
    endtask

    task automatic test_rates();
        int p1 [8] = '{6144, 1536, 384, 192, 96, 48, 32, 16};
        int p0 [5] = '{10416, 5216, 2608, 1744, 864};
        for (int i = 0; i < 8; i++) measure(1, 3'(i), p1[i]);
        for (int i = 0; i < 5; i++) measure(0, 3'(i + 3), p0[i]);
    endtask

    task automatic test_ignore();
        do_reset();
        send(8'hAA, 3'b111);
        fork
            frame_check(1, 11'h554, 16, "ignore_wr");
            begin
                step(40);
                tx_data = 8'h33;
                baud_select = 3'b000;
                tx_wr = 1'b1;
                step(1);
                tx_wr = 1'b0;
                step(30);
                tx_data = 8'h00;
                baud_select = 3'b010;
            end
        join
        step(1);
        total++;
        if (outs(1) !== 3'b100) $display("FAIL ignore_idle: txd,busy,done=%b required 100", outs(1));
        else passed++;
    endtask

    task automatic test_enable();
        logic ok;
        do_reset();
        tx_en = 1'b0;
        tx_data = 8'h33;
        tx_wr = 1'b1;
        ok = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step(1);
            if ({outs(0), outs(1)} !== 6'b100100) ok = 1'b0;
        end
        tx_wr = 1'b0;
        tx_en = 1'b1;
        total++;
        if (!ok) $display("FAIL en_off: a frame started with tx_en=0, required txd=1 busy=0");
        else passed++;
        send(8'h89, 3'b111);
        fork
            frame_check(1, 11'h712, 16, "en_drop");
            begin
                step(4 * 16 + 8);
                tx_en = 1'b0;
            end
        join
        tx_en = 1'b1;
    endtask

    task automatic test_rst_mid();
        logic ok;
        do_reset();
        send(8'hAA, 3'b111);
        step(3 * 16 + 5);
        rst = 1'b1;
        step(1);
        total++;
        if (outs(1) !== 3'b100) $display("FAIL rst_mid: txd,busy,done=%b required 100", outs(1));
        else passed++;
        rst = 1'b0;
        ok = 1'b1;
        for (int c = 0; c < 40; c++) begin
            step(1);
            if (outs(1) !== 3'b100) ok = 1'b0;
        end
        total++;
        if (!ok) $display("FAIL rst_no_resume: line left idle after reset, required 100");
        else passed++;
        send(8'hCC, 3'b111);
        frame_check(1, 11'h598, 16, "after_rst");
    endtask

    task automatic test_back_to_back();
        do_reset();
        tx_data = 8'h55;
        baud_select = 3'b111;
        tx_wr = 1'b1;
        step(1);
        frame_check(1, 11'h4AA, 16, "b2b_first");
        tx_data = 8'hCC;
        step(1);
        tx_wr = 1'b0;
        frame_check(1, 11'h598, 16, "b2b_second");
        do_reset();
    endtask

    initial begin
        test_reset();
        test_aa();
        test_bytes();
        test_rates();
        test_ignore();
        test_enable();
        test_rst_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
